// File: rtl/rgb2bayer.sv
// rgb2bayer: re-mosaics a 24-bit RGB pixel stream into an 8-bit Bayer stream
// with a single-cycle registered output path.
module rgb2bayer #(
  parameter int unsigned DISP_WIDTH    = 640,
  parameter int unsigned DISP_HIGHT    = 480,
  parameter int unsigned BAYER_PATTERN = 0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        frame_vsync,
  input  logic        data_in_valid,
  input  logic [23:0] data_in,
  output logic        frame_vsync_out,
  output logic        data_out_valid,
  output logic [7:0]  data_out,
  output logic        frame_done,
  output logic        overflow
);

  localparam int unsigned COL_W = (DISP_WIDTH > 1) ? $clog2(DISP_WIDTH) : 1;
  localparam int unsigned ROW_W = (DISP_HIGHT > 1) ? $clog2(DISP_HIGHT) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(DISP_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(DISP_HIGHT - 1);
  localparam logic [1:0]       PAT_OFS  = 2'(BAYER_PATTERN);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [COL_W-1:0] col_q, col_d, col_eff;
  logic [ROW_W-1:0] row_q, row_d, row_eff;
  logic             vsync_q;
  logic             overflow_q, overflow_d;
  logic             valid_q, valid_d;
  logic [7:0]       data_q, data_d;
  logic             done_q, done_d;
  logic             vs_rise;
  logic             accept;
  logic [1:0]       phase;

  // State register and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      col_q      <= '0;
      row_q      <= '0;
      vsync_q    <= 1'b0;
      overflow_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      col_q      <= col_d;
      row_q      <= row_d;
      vsync_q    <= frame_vsync;
      overflow_q <= overflow_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      done_q     <= done_d;
    end
  end

  // Next-state: frame restart, position tracking, channel select, overflow
  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    overflow_d = overflow_q;
    valid_d    = 1'b0;
    data_d     = data_q;
    done_d     = 1'b0;
    phase      = 2'b00;

    vs_rise = frame_vsync & ~vsync_q;
    // A pixel arriving with the vsync edge is pixel (0,0) of the new frame
    col_eff = vs_rise ? '0 : col_q;
    row_eff = vs_rise ? '0 : row_q;
    accept  = data_in_valid & (vs_rise | (state_q == ACTIVE));

    if (vs_rise) begin
      state_d    = ACTIVE;
      col_d      = '0;
      row_d      = '0;
      overflow_d = 1'b0;
    end

    if (accept) begin
      valid_d = 1'b1;
      phase   = {row_eff[0], col_eff[0]} ^ PAT_OFS;
      case (phase)
        2'b00:   data_d = data_in[23:16];
        2'b11:   data_d = data_in[7:0];
        default: data_d = data_in[15:8];
      endcase
      if (col_eff == COL_LAST) begin
        if (row_eff == ROW_LAST) begin
          // Last pixel: park counters until the next frame
          state_d = DONE;
          done_d  = 1'b1;
          col_d   = col_eff;
          row_d   = row_eff;
        end else begin
          col_d = '0;
          row_d = row_eff + ROW_W'(1);
        end
      end else begin
        col_d = col_eff + COL_W'(1);
      end
    end else if (data_in_valid && (state_q == DONE) && !vs_rise) begin
      overflow_d = 1'b1;
    end
  end

  assign frame_vsync_out = vsync_q;
  assign data_out_valid  = valid_q;
  assign data_out        = data_q;
  assign frame_done      = done_q;
  assign overflow        = overflow_q;

endmodule

// File: tb/tb_rgb2bayer.sv
// Scoreboard bench for rgb2bayer: three 4x2 instances (RGGB, BGGR, GRBG)
// share one stimulus stream; expected samples are queued at drive time.
module tb_rgb2bayer;

  localparam int W = 4;
  localparam int H = 2;
  localparam int NDUT = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        frame_vsync;
  logic        data_in_valid;
  logic [23:0] data_in;

  logic       vso [NDUT];
  logic       dv  [NDUT];
  logic [7:0] dout[NDUT];
  logic       dn  [NDUT];
  logic       ov  [NDUT];

  always #5 clk = ~clk;

  rgb2bayer #(.DISP_WIDTH(W), .DISP_HIGHT(H), .BAYER_PATTERN(0)) u_rggb (
    .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync), .data_in_valid(data_in_valid),
    .data_in(data_in), .frame_vsync_out(vso[0]), .data_out_valid(dv[0]),
    .data_out(dout[0]), .frame_done(dn[0]), .overflow(ov[0]));

  rgb2bayer #(.DISP_WIDTH(W), .DISP_HIGHT(H), .BAYER_PATTERN(3)) u_bggr (
    .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync), .data_in_valid(data_in_valid),
    .data_in(data_in), .frame_vsync_out(vso[1]), .data_out_valid(dv[1]),
    .data_out(dout[1]), .frame_done(dn[1]), .overflow(ov[1]));

  rgb2bayer #(.DISP_WIDTH(W), .DISP_HIGHT(H), .BAYER_PATTERN(1)) u_grbg (
    .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync), .data_in_valid(data_in_valid),
    .data_in(data_in), .frame_vsync_out(vso[2]), .data_out_valid(dv[2]),
    .data_out(dout[2]), .frame_done(dn[2]), .overflow(ov[2]));

  typedef struct packed {
    logic [NDUT-1:0][7:0] d;
    logic                 done;
  } exp_t;

  exp_t sb[$];

  int checks   = 0;
  int failures = 0;

  // Reference model state
  int         m_state;   // 0 idle, 1 active, 2 done
  int         m_col;
  int         m_row;
  logic       m_ovf;
  logic       m_prev_vs;
  logic [7:0] m_last[NDUT];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // CFA layout written out as the 2x2 tile, row-major
  function automatic logic [7:0] pick(input int dut, input int r, input int c,
                                      input logic [23:0] px);
    string lay;
    byte   ch;
    case (dut)
      0:       lay = "RGGB";
      1:       lay = "BGGR";
      default: lay = "GRBG";
    endcase
    ch = lay[(r % 2) * 2 + (c % 2)];
    case (ch)
      "R":     return px[23:16];
      "G":     return px[15:8];
      default: return px[7:0];
    endcase
  endfunction

  task automatic model_reset();
    m_state   = 0;
    m_col     = 0;
    m_row     = 0;
    m_ovf     = 1'b0;
    m_prev_vs = 1'b0;
    for (int i = 0; i < NDUT; i++) m_last[i] = 8'h00;
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("%s_u%0d_vso", tag, i), 32'(vso[i]), 32'd0);
      check($sformatf("%s_u%0d_valid", tag, i), 32'(dv[i]), 32'd0);
      check($sformatf("%s_u%0d_data", tag, i), 32'(dout[i]), 32'd0);
      check($sformatf("%s_u%0d_done", tag, i), 32'(dn[i]), 32'd0);
      check($sformatf("%s_u%0d_ovf", tag, i), 32'(ov[i]), 32'd0);
    end
  endtask

  // Drive one cycle of stimulus, update the model, then compare after the edge
  task automatic step(input string tag, input logic vs, input logic v, input logic [23:0] px);
    exp_t e;
    logic acc;
    frame_vsync   = vs;
    data_in_valid = v;
    data_in       = px;
    if (vs && !m_prev_vs) begin
      m_state = 1;
      m_col   = 0;
      m_row   = 0;
      m_ovf   = 1'b0;
    end
    acc = v && (m_state == 1);
    if (acc) begin
      for (int i = 0; i < NDUT; i++) e.d[i] = pick(i, m_row, m_col, px);
      e.done = (m_row == H - 1) && (m_col == W - 1);
      sb.push_back(e);
      if (e.done) m_state = 2;
      else if (m_col == W - 1) begin
        m_col = 0;
        m_row++;
      end else m_col++;
    end else if (v && m_state == 2) begin
      m_ovf = 1'b1;
    end
    m_prev_vs = vs;

    @(posedge clk);
    #1;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      for (int i = 0; i < NDUT; i++) begin
        check($sformatf("%s_u%0d_valid", tag, i), 32'(dv[i]), 32'd1);
        check($sformatf("%s_u%0d_data", tag, i), 32'(dout[i]), 32'(e.d[i]));
        check($sformatf("%s_u%0d_done", tag, i), 32'(dn[i]), 32'(e.done));
        m_last[i] = e.d[i];
      end
    end else begin
      for (int i = 0; i < NDUT; i++) begin
        check($sformatf("%s_u%0d_valid", tag, i), 32'(dv[i]), 32'd0);
        check($sformatf("%s_u%0d_hold", tag, i), 32'(dout[i]), 32'(m_last[i]));
        check($sformatf("%s_u%0d_done", tag, i), 32'(dn[i]), 32'd0);
      end
    end
    for (int i = 0; i < NDUT; i++) begin
      check($sformatf("%s_u%0d_ovf", tag, i), 32'(ov[i]), 32'(m_ovf));
      check($sformatf("%s_u%0d_vso", tag, i), 32'(vso[i]), 32'(vs));
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    frame_vsync   = 1'b0;
    data_in_valid = 1'b0;
    data_in       = 24'h0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst_n = 1'b1;

    // Pixels before any frame sync are ignored
    step("idle", 1'b0, 1'b1, 24'hA1B2C3);
    step("idle", 1'b0, 1'b1, 24'h445566);

    // Contiguous frame, constant pixel
    step("f1_vs", 1'b1, 1'b0, 24'h0);
    for (int k = 0; k < W * H; k++) step("f1", 1'b0, 1'b1, 24'h112233);
    step("f1_tail", 1'b0, 1'b0, 24'h0);

    // Gapped frame: valid toggles 1,0,1,0
    step("f2_vs", 1'b1, 1'b0, 24'h0);
    for (int k = 0; k < 2 * W * H; k++) step("f2", 1'b0, (k % 2) == 0, 24'h112233);

    // Overflow: 10 pixels into an 8-pixel frame, distinct channel values
    step("f3_vs", 1'b1, 1'b0, 24'h0);
    for (int k = 0; k < 10; k++) step("f3", 1'b0, 1'b1, 24'(k * 24'h030201 + 24'h102030));
    step("f3_hold", 1'b0, 1'b0, 24'h0);
    // Next frame sync clears overflow; pixel coincident with the edge is (0,0)
    step("f4_vs", 1'b1, 1'b1, 24'hC0FFEE);
    for (int k = 0; k < 4; k++) step("f4", 1'b0, 1'b1, 24'($urandom));

    // Mid-frame sync after 5 pixels, then a full frame
    step("f4_vs2", 1'b1, 1'b0, 24'h0);
    for (int k = 0; k < W * H; k++) step("f5", 1'b0, 1'b1, 24'($urandom));
    step("f5_over", 1'b0, 1'b1, 24'h777777);

    // Asynchronous reset in the middle of a frame
    step("f6_vs", 1'b1, 1'b0, 24'h0);
    for (int k = 0; k < 3; k++) step("f6", 1'b0, 1'b1, 24'h5A6B7C);
    data_in_valid = 1'b1;
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) step("postrst", 1'b0, 1'b1, 24'h998877);
    step("f7_vs", 1'b1, 1'b1, 24'h010203);
    for (int k = 0; k < W * H - 1; k++) step("f7", 1'b0, 1'b1, 24'($urandom));
    step("f7_tail", 1'b0, 1'b0, 24'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
